mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port memory.
// Define MEM_ARB_TIMEOUT_EN to abort a transaction that waits TIMEOUT BUSY cycles for mem_ready.
module mem_bus_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_done,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
  logic                  m0_done_q, m0_done_d, m1_done_q, m1_done_d;
  logic                  mem_re_q, mem_re_d, mem_we_q, mem_we_d;

  logic any_req;
  logic sel_m1;
  logic timeout_hit;

  // Contention goes to whichever requester did not own the previous transaction.
  assign any_req = m0_req | m1_req;
  assign sel_m1  = m1_req & (~m0_req | ~last_owner_q);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (state_q == ST_BUSY) && !mem_ready
                       && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if ((state_q == ST_BUSY) && !mem_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  // TIMEOUT has no effect when no counter is built.
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req) state_d = ST_BUSY;
      ST_BUSY: if (mem_ready || timeout_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Transaction latching, completion status, and registered grant/enable outputs.
  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = sel_m1;
          we_d    = sel_m1 ? m1_we    : m0_we;
          addr_d  = sel_m1 ? m1_addr  : m0_addr;
          wdata_d = sel_m1 ? m1_wdata : m0_wdata;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          if (!we_q) rdata_d = mem_rdata;
          err_d = 1'b0;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      ST_DONE: last_owner_d = owner_q;
      default: ;
    endcase
    m0_gnt_d  = (state_d != ST_IDLE) && !owner_d;
    m1_gnt_d  = (state_d != ST_IDLE) &&  owner_d;
    m0_done_d = (state_d == ST_DONE) && !owner_d;
    m1_done_d = (state_d == ST_DONE) &&  owner_d;
    mem_re_d  = (state_d == ST_BUSY) && !we_d;
    mem_we_d  = (state_d == ST_BUSY) &&  we_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      m0_gnt_q     <= 1'b0;
      m1_gnt_q     <= 1'b0;
      m0_done_q    <= 1'b0;
      m1_done_q    <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      m0_gnt_q     <= m0_gnt_d;
      m1_gnt_q     <= m1_gnt_d;
      m0_done_q    <= m0_done_d;
      m1_done_q    <= m1_done_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign m0_gnt    = m0_gnt_q;
  assign m1_gnt    = m1_gnt_q;
  assign m0_done   = m0_done_q;
  assign m1_done   = m1_done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic and resets.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned TO = 15;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_done, m1_gnt, m1_done;
  logic [DW-1:0] rdata;
  logic          err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re, mem_we;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  mem_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done),
    .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, whether it is in its completion cycle, how long it waited.
  int            m_own;
  bit            m_fin;
  int            m_wait;
  int            m_last;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  bit            m_err;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own   = -1;
    m_fin   = 1'b0;
    m_wait  = 0;
    m_last  = 1;
    m_rdata = '0;
    m_err   = 1'b0;
  endtask

  task automatic model_step();
    int w;
    if (m_fin) begin
      m_last = m_own;
      m_own  = -1;
      m_fin  = 1'b0;
    end else if (m_own >= 0) begin
      if (mem_ready) begin
        if (!m_we) m_rdata = mem_rdata;
        m_err = 1'b0;
        m_fin = 1'b1;
      end else begin
        m_wait++;
        if (TO_EN && m_wait >= int'(TO)) begin
          m_err   = 1'b1;
          m_rdata = '0;
          m_fin   = 1'b1;
        end
      end
    end else if (m0_req || m1_req) begin
      if (m0_req && m1_req) w = 1 - m_last;
      else                  w = m1_req ? 1 : 0;
      m_own   = w;
      m_wait  = 0;
      m_we    = (w == 1) ? m1_we    : m0_we;
      m_addr  = (w == 1) ? m1_addr  : m0_addr;
      m_wdata = (w == 1) ? m1_wdata : m0_wdata;
    end
  endtask

  task automatic check_outputs();
    bit busy;
    busy = (m_own >= 0) && !m_fin;
    check("m0_gnt",  m0_gnt,  m_own == 0);
    check("m1_gnt",  m1_gnt,  m_own == 1);
    check("m0_done", m0_done, m_fin && m_own == 0);
    check("m1_done", m1_done, m_fin && m_own == 1);
    check("mem_re",  mem_re,  busy && !m_we);
    check("mem_we",  mem_we,  busy && m_we);
    check("rdata",   rdata,   m_rdata);
    check("err",     err,     m_err);
    if (busy) begin
      check("mem_addr",  mem_addr,  m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
    end
    check("gnt_exclusive", m0_gnt & m1_gnt, 0);
    check("en_exclusive",  mem_re & mem_we, 0);
  endtask

  // One clock: advance the model on the edge, then compare away from it.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (!reset) model_step();
    check_outputs();
  endtask

  task automatic reset_assert();
    #2 reset = 1'b1;
    #1 model_reset();
    check_outputs();
  endtask

  task automatic apply_reset();
    reset_assert();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic new_req(input int r);
    if (r == 0) begin
      m0_req = 1'b1; m0_we = 1'($urandom); m0_addr = AW'($urandom); m0_wdata = DW'($urandom);
    end else begin
      m1_req = 1'b1; m1_we = 1'($urandom); m1_addr = AW'($urandom); m1_wdata = DW'($urandom);
    end
  endtask

  task automatic scramble(input int r);
    if (r == 0) begin
      m0_we = 1'($urandom); m0_addr = AW'($urandom); m0_wdata = DW'($urandom);
    end else begin
      m1_we = 1'($urandom); m1_addr = AW'($urandom); m1_wdata = DW'($urandom);
    end
  endtask

  task automatic drop_req(input int r);
    if (r == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
  endtask

  function automatic bit req_of(input int r);
    return (r == 0) ? m0_req : m1_req;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int nwe, ndone, first, nre, n;
    int order [4];
    logic          to_err;
    logic [DW-1:0] to_rdata;

    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    model_reset();
    cycle();
    cycle();
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;

    // Single read by m0, memory ready in the first BUSY cycle.
    m0_req = 1; m0_we = 0; m0_addr = 16'h0010; m0_wdata = 32'h1111_2222;
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    cycle();
    check("rd_gnt", m0_gnt, 1);
    check("rd_re", mem_re, 1);
    check("rd_addr", mem_addr, 16'h0010);
    cycle();
    check("rd_done", m0_done, 1);
    check("rd_rdata", rdata, 32'hDEADBEEF);
    check("rd_err", err, 0);
    m0_req = 0; mem_ready = 0; mem_rdata = 32'h0BAD_0BAD;
    cycle();
    check("rd_idle_gnt", m0_gnt, 0);

    // Single write by m1, memory ready three cycles late.
    m1_req = 1; m1_we = 1; m1_addr = 16'h00FF; m1_wdata = 32'h12345678;
    nwe = 0; ndone = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (mem_we) begin
        nwe++;
        check("wr_wdata", mem_wdata, 32'h12345678);
      end
      mem_ready = (nwe == 4);
      if (m1_done) begin
        ndone++;
        m1_req = 0;
      end
    end
    mem_ready = 0;
    check("wr_we_cycles", nwe, 4);
    check("wr_done_pulses", ndone, 1);
    check("wr_rdata_kept", rdata, 32'hDEADBEEF);

    // m1 withdraws its request while BUSY; the transaction still completes.
    m1_req = 1; m1_we = 0; m1_addr = 16'h0300;
    cycle();
    m1_req = 0; m1_addr = 16'h0555;
    cycle();
    mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (m1_done) ndone++;
    end
    mem_ready = 0;
    check("wd_done", ndone, 1);
    check("wd_rdata", rdata, 32'hCAFEF00D);

    // mem_ready never arrives.
    m0_req = 1; m0_we = 0; m0_addr = 16'h0042; mem_rdata = 32'hFFFF_FFFF;
    first = 0; nre = 0; to_err = 0; to_rdata = '1;
    for (int i = 1; i <= 100; i++) begin
      cycle();
      if (mem_re) nre++;
      if (m0_done && first == 0) begin
        first = i; to_err = err; to_rdata = rdata; m0_req = 0;
      end
    end
`ifdef MEM_ARB_TIMEOUT_EN
    check("to_done_cycle", first, 16);
    check("to_re_cycles", nre, 15);
    check("to_err", to_err, 1);
    check("to_rdata", to_rdata, 0);
`else
    check("to_no_done", first, 0);
    check("to_re_cycles", nre, 100);
`endif
    m0_req = 0;

    // Reset in the 2nd BUSY cycle abandons the transaction.
    apply_reset();
    m0_req = 1; m0_we = 0; m0_addr = 16'h0077;
    cycle();
    cycle();
    check("mr_pre_re", mem_re, 1);
    reset_assert();
    check("mr_re", mem_re, 0);
    check("mr_gnt", m0_gnt, 0);
    check("mr_done", m0_done, 0);
    cycle();
    reset = 1'b0;
    mem_ready = 1; mem_rdata = 32'h5A5A1234;
    cycle();
    check("mr_gnt_after", m0_gnt, 1);
    cycle();
    check("mr_done_after", m0_done, 1);
    check("mr_rdata_after", rdata, 32'h5A5A1234);
    m0_req = 0; mem_ready = 0;
    cycle();

    // Both requesters hold req right after reset: round-robin order 0,1,0,1.
    apply_reset();
    new_req(0);
    new_req(1);
    mem_ready = 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      mem_rdata = DW'($urandom);
      cycle();
      for (int r = 0; r < 2; r++) begin
        if ((r == 0) ? m0_done : m1_done) begin
          if (n < 4) order[n] = r;
          n++;
          new_req(r);
        end
      end
    end
    m0_req = 0; m1_req = 0; mem_ready = 0;
    cycle();
    cycle();
    check("rr_count", n >= 4, 1);
    check("rr_owner0", order[0], 0);
    check("rr_owner1", order[1], 1);
    check("rr_owner2", order[2], 0);
    check("rr_owner3", order[3], 1);

    // Randomized traffic: hold requests until done, random withdrawals, slow memory phases.
    for (int i = 0; i < 3000; i++) begin
      cycle();
      for (int r = 0; r < 2; r++) begin
        if (m_own == r && m_fin) begin
          if ($urandom_range(1, 0) == 1) new_req(r);
          else                           drop_req(r);
        end else if (m_own == r) begin
          scramble(r);
          if ($urandom_range(7, 0) == 0) drop_req(r);
        end else if (!req_of(r)) begin
          if ($urandom_range(2, 0) == 0) new_req(r);
        end
      end
      if ((i % 400) < 100) mem_ready = ($urandom_range(19, 0) == 0);
      else                 mem_ready = 1'($urandom);
      mem_rdata = DW'($urandom);
      if (i == 1500 || i == 2222) apply_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
